multicycle_sequencer: RTL and testbench

- Multi-cycle instruction sequencer that steps the CPU datapath through FETCH/DECODE/EXECUTE/MEM/WB.
- Consumes the decoded control signals from the control unit and gates them into single-cycle strobes.
- Handles the req/ack handshakes to instruction and data memory, counts retired instructions, and traps on HALT or on a memory timeout.
- Sits between the control unit, the register file/PC/IR enables and both memory ports.

---
 rtl/seq_pkg.sv | 32 +++
 rtl/ack_timeout_counter.sv | 45 ++++
 rtl/multicycle_sequencer.sv | 167 ++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encodings and the
// opcode map agreed with the control unit.
package seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_HALT    = 3'd6,
        ST_ERROR   = 3'd7
    } state_t;

    localparam logic [6:0] OPC_HALT = 7'b1111111;
    localparam logic [6:0] OPC_LD   = 7'b0000011;
    localparam logic [6:0] OPC_ST   = 7'b0000111;
    localparam logic [6:0] OPC_ADD  = 7'b0001011;
    localparam logic [6:0] OPC_SUB  = 7'b0001111;
    localparam logic [6:0] OPC_INV  = 7'b0010011;
    localparam logic [6:0] OPC_LSL  = 7'b0010111;
    localparam logic [6:0] OPC_LSR  = 7'b0011011;
    localparam logic [6:0] OPC_AND  = 7'b0011111;
    localparam logic [6:0] OPC_OR   = 7'b0100011;
    localparam logic [6:0] OPC_SLT  = 7'b0100111;
    localparam logic [6:0] OPC_BEQ  = 7'b0101111;
    localparam logic [6:0] OPC_BNE  = 7'b0110011;
    localparam logic [6:0] OPC_JMP  = 7'b0110111;
    localparam logic [6:0] OPC_LUI  = 7'b0111011;

endpackage

// File: rtl/ack_timeout_counter.sv
// Wait timer shared by the FETCH and MEM handshakes. It counts cycles spent
// waiting without an ack and flags expiry on the last permitted cycle, so an
// ack arriving in that same cycle still wins.
module ack_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic wait_i,
    input  logic ack_i,
    output logic expired_o
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Clear whenever not waiting or when the ack lands, so every new wait starts at zero.
    always_comb begin
        if (!wait_i || ack_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Wait counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign expired_o = 1'b0;
        end else begin : g_timeout
            assign expired_o = wait_i && !ack_i && (cnt_q == CW'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer: walks FETCH/DECODE/EXECUTE/MEM/WB,
// drives memory handshakes, gates control-unit decodes into one-cycle
// strobes, counts retired instructions and traps on HALT or ack timeout.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [6:0]       opcode,
    input  logic             data_read_en,
    input  logic             data_write_en,
    input  logic             reg_write_en,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_load_en,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             reg_write_strobe,
    output logic             pc_write_en,
    output logic [2:0]       state_o,
    output logic             busy,
    output logic             halted,
    output logic             bus_error,
    output logic [CNT_W-1:0] instr_count
);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   count_q;
    logic               halted_q;
    logic               bus_error_q;

    logic               wait_s;
    logic               ack_s;
    logic               expired_s;
    logic               retire_s;

    assign wait_s = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign ack_s  = ((state_q == ST_FETCH) && imem_ack) || ((state_q == ST_MEM) && dmem_ack);

    ack_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .wait_i    (wait_s),
        .ack_i     (ack_s),
        .expired_o (expired_s)
    );

    // Next-state and strobe decode from the registered state plus current inputs.
    always_comb begin
        state_d          = state_q;
        retire_s         = 1'b0;
        imem_req         = 1'b0;
        ir_load_en       = 1'b0;
        dmem_req         = 1'b0;
        dmem_we          = 1'b0;
        reg_write_strobe = 1'b0;
        pc_write_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load_en = 1'b1;
                    state_d    = ST_DECODE;
                end else if (expired_s) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (opcode == OPC_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (data_read_en || data_write_en) begin
                    state_d = ST_MEM;
                end else if (reg_write_en) begin
                    state_d = ST_WB;
                end else begin
                    retire_s = 1'b1;
                end
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                // A load wins if the control unit asserts both qualifiers.
                dmem_we  = data_write_en & ~data_read_en;
                if (dmem_ack) begin
                    if (data_read_en) begin
                        state_d = ST_WB;
                    end else begin
                        retire_s = 1'b1;
                    end
                end else if (expired_s) begin
                    state_d = ST_ERROR;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_WB: begin
                reg_write_strobe = 1'b1;
                retire_s         = 1'b1;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Retirement is the only instruction boundary where run is re-sampled.
        if (retire_s) begin
            pc_write_en = 1'b1;
            state_d     = run ? ST_FETCH : ST_IDLE;
        end else begin
            pc_write_en = 1'b0;
        end
    end

    // State, retire counter and sticky trap flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            halted_q    <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire_s) begin
                count_q <= count_q + CNT_W'(1);
            end
            if (state_d == ST_HALT) begin
                halted_q <= 1'b1;
            end
            if (state_d == ST_ERROR) begin
                bus_error_q <= 1'b1;
            end
        end
    end

    assign state_o     = state_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_HALT) && (state_q != ST_ERROR);
    assign halted      = halted_q;
    assign bus_error   = bus_error_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer. Inputs change 2 time units after
// each rising edge; outputs are sampled 1 unit later, well clear of the edge.
module tb_multicycle_sequencer;
    import seq_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             run;
    logic [6:0]       opcode;
    logic             data_read_en;
    logic             data_write_en;
    logic             reg_write_en;
    logic             imem_req;
    logic             imem_ack;
    logic             ir_load_en;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ack;
    logic             reg_write_strobe;
    logic             pc_write_en;
    logic [2:0]       state_o;
    logic             busy;
    logic             halted;
    logic             bus_error;
    logic [CNT_W-1:0] instr_count;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_sequencer #(
        .TIMEOUT (4),
        .CNT_W   (CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .run              (run),
        .opcode           (opcode),
        .data_read_en     (data_read_en),
        .data_write_en    (data_write_en),
        .reg_write_en     (reg_write_en),
        .imem_req         (imem_req),
        .imem_ack         (imem_ack),
        .ir_load_en       (ir_load_en),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_ack         (dmem_ack),
        .reg_write_strobe (reg_write_strobe),
        .pc_write_en      (pc_write_en),
        .state_o          (state_o),
        .busy             (busy),
        .halted           (halted),
        .bus_error        (bus_error),
        .instr_count      (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    // strb = {imem_req, ir_load_en, dmem_req, dmem_we, reg_write_strobe, pc_write_en}
    task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [5:0] strb);
        #1;
        check_eq({tag, " state"}, state_o, st);
        check_eq({tag, " strobes"},
                 {imem_req, ir_load_en, dmem_req, dmem_we, reg_write_strobe, pc_write_en}, strb);
    endtask

    // Control-unit decode model for the opcodes exercised here.
    task automatic set_instr(input logic [6:0] opc);
        opcode        = opc;
        data_read_en  = (opc == OPC_LD);
        data_write_en = (opc == OPC_ST);
        reg_write_en  = (opc == OPC_LD) || (opc == OPC_ADD);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        set_instr(OPC_ADD);
        nxt(); nxt();
        expect_cyc("reset", 3'd0, 6'b000000);
        check_eq("reset cnt", instr_count, 0);
        check_eq("reset flags", {busy, halted, bus_error}, 3'b000);

        // ADD with immediate ack, then LD with dmem ack two cycles late.
        reset = 1'b0; run = 1'b1; imem_ack = 1'b1;
        expect_cyc("idle", 3'd0, 6'b000000);
        nxt(); expect_cyc("add fetch", 3'd1, 6'b110000);
        nxt(); expect_cyc("add decode", 3'd2, 6'b000000);
        check_eq("add busy", busy, 1'b1);
        nxt(); expect_cyc("add exec", 3'd3, 6'b000000);
        nxt(); expect_cyc("add wb", 3'd5, 6'b000011);
        check_eq("add cnt pre", instr_count, 0);
        nxt(); set_instr(OPC_LD); expect_cyc("ld fetch", 3'd1, 6'b110000);
        check_eq("add cnt", instr_count, 1);
        nxt(); expect_cyc("ld decode", 3'd2, 6'b000000);
        nxt(); expect_cyc("ld exec", 3'd3, 6'b000000);
        nxt(); expect_cyc("ld mem1", 3'd4, 6'b001000);
        nxt(); expect_cyc("ld mem2", 3'd4, 6'b001000);
        nxt(); dmem_ack = 1'b1; expect_cyc("ld mem3", 3'd4, 6'b001000);
        nxt(); dmem_ack = 1'b0; run = 1'b0; expect_cyc("ld wb", 3'd5, 6'b000011);
        nxt(); expect_cyc("ld idle", 3'd0, 6'b000000);
        check_eq("ld cnt", instr_count, 2);

        // ST then BEQ; a stray dmem_ack during BEQ must be ignored.
        set_instr(OPC_ST); run = 1'b1;
        nxt(); expect_cyc("st fetch", 3'd1, 6'b110000);
        nxt(); expect_cyc("st decode", 3'd2, 6'b000000);
        nxt(); expect_cyc("st exec", 3'd3, 6'b000000);
        nxt(); dmem_ack = 1'b1; expect_cyc("st mem", 3'd4, 6'b001101);
        nxt(); set_instr(OPC_BEQ); expect_cyc("beq fetch", 3'd1, 6'b110000);
        check_eq("st cnt", instr_count, 3);
        nxt(); expect_cyc("beq decode", 3'd2, 6'b000000);
        nxt(); run = 1'b0; expect_cyc("beq exec", 3'd3, 6'b000001);
        nxt(); dmem_ack = 1'b0; expect_cyc("beq idle", 3'd0, 6'b000000);
        check_eq("beq cnt", instr_count, 4);

        // Three ADDs then HALT; HALT is sticky and ignores run and acks.
        reset = 1'b1; nxt(); reset = 1'b0;
        run = 1'b1; set_instr(OPC_ADD);
        for (int i = 0; i < 3; i++) begin
            nxt(); nxt(); nxt();
            nxt(); expect_cyc("halt-add wb", 3'd5, 6'b000011);
        end
        set_instr(OPC_HALT);
        nxt(); expect_cyc("halt fetch", 3'd1, 6'b110000);
        nxt(); expect_cyc("halt decode", 3'd2, 6'b000000);
        nxt(); expect_cyc("halt", 3'd6, 6'b000000);
        check_eq("halt flags", {busy, halted, bus_error}, 3'b010);
        check_eq("halt cnt", instr_count, 3);
        for (int i = 0; i < 10; i++) begin
            run = ~run; dmem_ack = ~dmem_ack;
            nxt(); expect_cyc("halt hold", 3'd6, 6'b000000);
        end
        check_eq("halt cnt hold", instr_count, 3);
        dmem_ack = 1'b0;
        reset = 1'b1; nxt(); reset = 1'b0;
        expect_cyc("halt reset", 3'd0, 6'b000000);
        check_eq("halt reset flags", {halted, instr_count}, 0);

        // Sixteen branches: counter walks 0..15 then wraps to 0.
        run = 1'b1; set_instr(OPC_BEQ); imem_ack = 1'b1;
        for (int i = 0; i < 16; i++) begin
            nxt(); nxt(); nxt();
            if (i == 15) run = 1'b0;
            check_eq("wrap cnt", instr_count, i);
        end
        nxt(); expect_cyc("wrap idle", 3'd0, 6'b000000);
        check_eq("wrap cnt end", instr_count, 0);

        // Fetch timeout: four cycles without ack lands in ERROR.
        set_instr(OPC_ADD); imem_ack = 1'b0; run = 1'b1;
        for (int k = 0; k < 4; k++) begin
            nxt(); expect_cyc("to fetch", 3'd1, 6'b100000);
        end
        nxt(); expect_cyc("timeout", 3'd7, 6'b000000);
        check_eq("timeout flags", {busy, halted, bus_error}, 3'b001);
        imem_ack = 1'b1;
        nxt(); nxt(); expect_cyc("error hold", 3'd7, 6'b000000);

        // Ack on the limit cycle wins.
        reset = 1'b1; nxt(); reset = 1'b0; imem_ack = 1'b0;
        check_eq("error reset", bus_error, 1'b0);
        for (int k = 0; k < 4; k++) begin
            nxt();
            if (k == 3) imem_ack = 1'b1;
            expect_cyc("ack limit fetch", 3'd1, (k == 3) ? 6'b110000 : 6'b100000);
        end
        nxt(); expect_cyc("ack limit decode", 3'd2, 6'b000000);
        check_eq("ack limit err", bus_error, 1'b0);

        // run dropped in EXECUTE: ADD still retires, then IDLE.
        nxt(); run = 1'b0; expect_cyc("runlow exec", 3'd3, 6'b000000);
        nxt(); expect_cyc("runlow wb", 3'd5, 6'b000011);
        nxt(); expect_cyc("runlow idle", 3'd0, 6'b000000);
        check_eq("runlow cnt", instr_count, 1);

        // Reset mid data handshake.
        run = 1'b1; set_instr(OPC_LD);
        nxt(); nxt(); nxt();
        nxt(); expect_cyc("rst mem", 3'd4, 6'b001000);
        reset = 1'b1;
        nxt(); reset = 1'b0;
        expect_cyc("rst mid", 3'd0, 6'b000000);
        check_eq("rst mid cnt", instr_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
